ahb_slave_mux: RTL and testbench
================================

# ahb_slave_mux

AHB-Lite response multiplexer and default slave for the peripheral bus. It takes the per-slave HSEL lines from the address decoder in the address phase and registers which slave owns the following data phase. It then routes that slave's HRDATA/HREADYOUT/HRESP back to the single master. Unmapped active transfers are answered by an internal default slave with the standard two-cycle ERROR response.

## Interface
- DATA_WIDTH, 32, width of HRDATA buses.
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HSEL_1..HSEL_4  in  1 each  decoder selects: clint, plic, uart0, spi0.
- HRDATA_1..HRDATA_4  in  DATA_WIDTH each  slave read data.
- HREADYOUT_1..HREADYOUT_4  in  1 each  slave ready.
- HRESP_1..HRESP_4  in  1 each  slave response (0 OKAY, 1 ERROR).
- HRDATA  out  DATA_WIDTH  muxed read data to master.
- HREADY  out  1  muxed ready to master and broadcast to all slaves.
- HRESP  out  1  muxed response to master.

## Operation
- Data-phase select register dsel[4:0] = {dflt, s4, s3, s2, s1}, one-hot or all-zero.
- Loaded only when HREADY==1 (current data phase completing); held otherwise.
- Load value:
  - s1 if HSEL_1;
  - else s2 if HSEL_2;
  - else s3 if HSEL_3;
  - else s4 if HSEL_4.
  - Lowest index wins on multiple HSEL; decoder ranges are disjoint, so this is defensive only.
  - else dflt if HTRANS[1]==1 (NONSEQ/SEQ);
  - else all-zero (idle/busy to an unmapped address).
- Output mux, combinational from dsel:
  - sN set: HRDATA=HRDATA_N, HREADY=HREADYOUT_N, HRESP=HRESP_N.
  - dflt set: HRDATA=0; HREADY and HRESP from the default-slave FSM.
  - all-zero: HRDATA=0, HREADY=1, HRESP=0.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE -> DS_ERR1 when HREADY==1 and an unmapped NONSEQ/SEQ is sampled (the dflt load condition).
  - DS_ERR1: HREADY=0, HRESP=1; always -> DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=1. Next state is DS_ERR1 if another unmapped active transfer is sampled this cycle, else DS_IDLE.
  - DS_IDLE with dflt set: cannot occur. Treat as HREADY=1, HRESP=0.
- A slave's IDLE/BUSY handling (zero-wait OKAY) remains that slave's responsibility; the mux forwards whatever the slave drives.

## Timing
- Reset (HRESET=1 at a clock edge): dsel=0, FSM=DS_IDLE. Outputs are therefore HRDATA=0, HREADY=1, HRESP=0 from the first cycle after reset.
- Reset mid-transfer aborts any wait state or ERROR sequence; HREADY=1 the next cycle.
- Select latency: dsel updates one cycle after the address phase, aligned with the data phase. No added latency on the response path; outputs are purely combinational from dsel, FSM and slave inputs.
- Back-to-back transfers: with HREADY=1 every cycle, dsel changes every cycle. Slave N's data phase and slave M's address phase overlap correctly.
- Wait states: while the owning slave holds HREADYOUT=0, dsel is frozen. HSEL/HTRANS changes in those cycles are ignored.
- Unmapped active transfer: exactly 2 data-phase cycles (ERR1, ERR2). The next address phase is sampled in the ERR2 cycle.
- HSEL inputs are ignored unless HREADY==1; no assumption is made on them otherwise.

## Test plan
- Reset: assert HRESET 2 cycles with slaves driving HRDATA_1=0xAAAA_AAAA, HREADYOUT_1=0 -> HRDATA=0, HREADY=1, HRESP=0 during and after reset.
- Routing: NONSEQ with HSEL_3=1, then IDLE; HRDATA_3=0x1234_5678, HREADYOUT_3=1 -> in the next cycle HRDATA=0x1234_5678, HREADY=1, HRESP=0. Repeat for slaves 1, 2, 4.
- Wait states: HSEL_2 transfer; slave 2 holds HREADYOUT_2=0 for 3 cycles while HSEL_4 is asserted -> HREADY=0 for 3 cycles, dsel stays slave 2. The slave-4 address is captured only on the cycle HREADYOUT_2=1.
- Unmapped NONSEQ (all HSEL=0, HTRANS=10) -> next two cycles are {HREADY=0, HRESP=1} then {HREADY=1, HRESP=1}. A third cycle follows with HREADY=1, HRESP=0 if the address phase in ERR2 is IDLE.
- Back-to-back unmapped SEQ, SEQ -> ERR1, ERR2, ERR1, ERR2, then DS_IDLE. Separately, unmapped IDLE (HTRANS=00) -> zero-wait OKAY, HRDATA=0.
- Mixed pipeline: slave1, unmapped, slave4 NONSEQ on consecutive ready cycles -> slave1 data, 2-cycle ERROR, then slave4 data. HRESET asserted during ERR1 returns HREADY=1, HRESP=0 next cycle.

Source files
------------

// File: rtl/ahb_slave_mux.sv
// ahb_slave_mux
//   AHB-Lite response multiplexer plus built-in default slave.
//   The address-phase HSEL lines are registered into a one-hot data-phase
//   owner (dsel). The owner's HRDATA/HREADYOUT/HRESP are routed back to the
//   master. Unmapped NONSEQ/SEQ transfers get a two-cycle ERROR response
//   from the internal default slave.
//
// Ports
//   HCLK, HRESET              clock, synchronous active-high reset
//   HTRANS                    master transfer type
//   HSEL_1..HSEL_4            decoder selects (clint, plic, uart0, spi0)
//   HRDATA_n/HREADYOUT_n/HRESP_n   per-slave responses
//   HRDATA/HREADY/HRESP       muxed response to master (HREADY also to slaves)
module ahb_slave_mux #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [1:0]            HTRANS,
    input  logic                  HSEL_1,
    input  logic                  HSEL_2,
    input  logic                  HSEL_3,
    input  logic                  HSEL_4,
    input  logic [DATA_WIDTH-1:0] HRDATA_1,
    input  logic [DATA_WIDTH-1:0] HRDATA_2,
    input  logic [DATA_WIDTH-1:0] HRDATA_3,
    input  logic [DATA_WIDTH-1:0] HRDATA_4,
    input  logic                  HREADYOUT_1,
    input  logic                  HREADYOUT_2,
    input  logic                  HREADYOUT_3,
    input  logic                  HREADYOUT_4,
    input  logic                  HRESP_1,
    input  logic                  HRESP_2,
    input  logic                  HRESP_3,
    input  logic                  HRESP_4,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic                  HRESP
);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    // dsel = {dflt, s4, s3, s2, s1}
    logic [4:0] dsel;
    logic [4:0] dsel_next;
    logic       active;
    ds_state_t  ds_state;
    logic       ds_ready;
    logic       ds_resp;

    // NONSEQ or SEQ
    assign active = HTRANS inside {2'b10, 2'b11};

    // Lowest-index select wins; unmapped active transfers go to the default slave.
    always_comb begin
        dsel_next = '0;
        if (HSEL_1)      dsel_next[0] = 1'b1;
        else if (HSEL_2) dsel_next[1] = 1'b1;
        else if (HSEL_3) dsel_next[2] = 1'b1;
        else if (HSEL_4) dsel_next[3] = 1'b1;
        else if (active) dsel_next[4] = 1'b1;
    end

    // Owner only advances when the current data phase completes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel <= '0;
        end else if (HREADY) begin
            dsel <= dsel_next;
        end
    end

    // Default slave: ERR1 (wait, ERROR) then ERR2 (ready, ERROR).
    // ERR2 completes the phase, so a new unmapped transfer can chain into ERR1.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ds_state <= DS_IDLE;
            ds_ready <= 1'b1;
            ds_resp  <= 1'b0;
        end else begin
            case (ds_state)
                DS_ERR1: begin
                    ds_state <= DS_ERR2;
                    ds_ready <= 1'b1;
                    ds_resp  <= 1'b1;
                end
                default: begin
                    if (HREADY && dsel_next[4]) begin
                        ds_state <= DS_ERR1;
                        ds_ready <= 1'b0;
                        ds_resp  <= 1'b1;
                    end else begin
                        ds_state <= DS_IDLE;
                        ds_ready <= 1'b1;
                        ds_resp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Response mux; an empty dsel answers as a zero-wait OKAY.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (dsel[0]) begin
            HRDATA = HRDATA_1;
            HREADY = HREADYOUT_1;
            HRESP  = HRESP_1;
        end else if (dsel[1]) begin
            HRDATA = HRDATA_2;
            HREADY = HREADYOUT_2;
            HRESP  = HRESP_2;
        end else if (dsel[2]) begin
            HRDATA = HRDATA_3;
            HREADY = HREADYOUT_3;
            HRESP  = HRESP_3;
        end else if (dsel[3]) begin
            HRDATA = HRDATA_4;
            HREADY = HREADYOUT_4;
            HRESP  = HRESP_4;
        end else if (dsel[4]) begin
            HREADY = ds_ready;
            HRESP  = ds_resp;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// tb_ahb_slave_mux
//   Directed table of per-cycle vectors followed by randomized traffic
//   checked against a transaction-level model (owner index + data-phase
//   cycle count).
module tb_ahb_slave_mux;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  HTRANS;
    logic [3:0]  sel;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
    logic [31:0] rd [4];
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_slave_mux #(.DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS),
        .HSEL_1(sel[0]), .HSEL_2(sel[1]), .HSEL_3(sel[2]), .HSEL_4(sel[3]),
        .HRDATA_1(rd[0]), .HRDATA_2(rd[1]), .HRDATA_3(rd[2]), .HRDATA_4(rd[3]),
        .HREADYOUT_1(rdy[0]), .HREADYOUT_2(rdy[1]), .HREADYOUT_3(rdy[2]), .HREADYOUT_4(rdy[3]),
        .HRESP_1(rsp[0]), .HRESP_2(rsp[1]), .HRESP_3(rsp[2]), .HRESP_4(rsp[3]),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  trans;
        logic [3:0]  sel;
        logic [3:0]  rdy;
        logic [3:0]  rsp;
        logic        exp_rdy;
        logic        exp_rsp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic r, logic [1:0] t, logic [3:0] s, logic [3:0] y,
                               logic [3:0] p, logic er, logic ep, logic [31:0] ed);
        vec_t x;
        x.rst = r; x.trans = t; x.sel = s; x.rdy = y; x.rsp = p;
        x.exp_rdy = er; x.exp_rsp = ep; x.exp_data = ed;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: who owns the data phase and how long it has lasted.
    int owner;  // 0 none, 1..4 slave, 5 default slave
    int dcnt;   // cycles already spent in this data phase

    task automatic model_outputs(output logic er, output logic ep, output logic [31:0] ed);
        if (owner == 0) begin
            er = 1'b1; ep = 1'b0; ed = '0;
        end else if (owner == 5) begin
            er = (dcnt >= 1); ep = 1'b1; ed = '0;
        end else begin
            er = rdy[owner-1]; ep = rsp[owner-1]; ed = rd[owner-1];
        end
    endtask

    task automatic model_clock(input logic er);
        if (HRESET) begin
            owner = 0; dcnt = 0;
        end else if (er) begin
            owner = 0;
            for (int k = 3; k >= 0; k--)
                if (sel[k]) owner = k + 1;
            if (owner == 0 && HTRANS[1]) owner = 5;
            dcnt = 0;
        end else begin
            dcnt++;
        end
    endtask

    initial begin
        logic        er, ep;
        logic [31:0] ed;

        HRESET = 1'b1; HTRANS = 2'b00; sel = '0; rdy = 4'b1110; rsp = '0;
        rd[0] = 32'hAAAA_AAAA; rd[1] = 32'h2222_2222;
        rd[2] = 32'h1234_5678; rd[3] = 32'h4444_4444;

        // reset, held while slave 1 drives data/not-ready
        vecs.push_back(v(1, 2'b00, 4'b0000, 4'b1110, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(1, 2'b10, 4'b0001, 4'b1110, 4'b0000, 1, 0, 32'h0));
        // routing 3, 1, 2, 4 (slave 4 returns ERROR)
        vecs.push_back(v(0, 2'b10, 4'b0100, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h1234_5678));
        vecs.push_back(v(0, 2'b10, 4'b0001, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'hAAAA_AAAA));
        vecs.push_back(v(0, 2'b10, 4'b0010, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h2222_2222));
        vecs.push_back(v(0, 2'b10, 4'b1000, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b1000, 1, 1, 32'h4444_4444));
        // wait states on slave 2 while slave 4 address is pending
        vecs.push_back(v(0, 2'b10, 4'b0010, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 2'b10, 4'b1000, 4'b1101, 4'b0000, 0, 0, 32'h2222_2222));
        vecs.push_back(v(0, 2'b10, 4'b1000, 4'b1101, 4'b0000, 0, 0, 32'h2222_2222));
        vecs.push_back(v(0, 2'b10, 4'b1000, 4'b1101, 4'b0000, 0, 0, 32'h2222_2222));
        vecs.push_back(v(0, 2'b10, 4'b1000, 4'b1111, 4'b0000, 1, 0, 32'h2222_2222));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h4444_4444));
        // unmapped NONSEQ; HSEL_1 during ERR1 must be ignored
        vecs.push_back(v(0, 2'b10, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 2'b10, 4'b0001, 4'b1111, 4'b0000, 0, 1, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 1, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h0));
        // back-to-back unmapped SEQ, SEQ
        vecs.push_back(v(0, 2'b11, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 2'b11, 4'b0000, 4'b1111, 4'b0000, 0, 1, 32'h0));
        vecs.push_back(v(0, 2'b11, 4'b0000, 4'b1111, 4'b0000, 1, 1, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 0, 1, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 1, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h0));
        // unmapped IDLE / BUSY: zero-wait OKAY
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 2'b01, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h0));
        // mixed pipeline: slave1, unmapped, slave4
        vecs.push_back(v(0, 2'b10, 4'b0001, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 2'b10, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'hAAAA_AAAA));
        vecs.push_back(v(0, 2'b10, 4'b1000, 4'b1111, 4'b0000, 0, 1, 32'h0));
        vecs.push_back(v(0, 2'b10, 4'b1000, 4'b1111, 4'b0000, 1, 1, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h4444_4444));
        // reset during ERR1
        vecs.push_back(v(0, 2'b10, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h0));
        vecs.push_back(v(1, 2'b00, 4'b0000, 4'b1111, 4'b0000, 0, 1, 32'h0));
        vecs.push_back(v(0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 32'h0));

        @(posedge HCLK); #1;

        foreach (vecs[i]) begin
            HRESET = vecs[i].rst; HTRANS = vecs[i].trans; sel = vecs[i].sel;
            rdy = vecs[i].rdy; rsp = vecs[i].rsp;
            #1;
            check($sformatf("row%0d hready", i), {31'd0, HREADY}, {31'd0, vecs[i].exp_rdy});
            check($sformatf("row%0d hresp", i), {31'd0, HRESP}, {31'd0, vecs[i].exp_rsp});
            check($sformatf("row%0d hrdata", i), HRDATA, vecs[i].exp_data);
            @(posedge HCLK); #1;
        end

        // last table row leaves an idle bus with no owner
        owner = 0; dcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            HRESET = ($urandom_range(63) == 0);
            HTRANS = 2'($urandom_range(3));
            r = $urandom_range(9);
            if (r < 4)       sel = 4'(1 << r);
            else if (r < 8)  sel = '0;
            else             sel = 4'($urandom_range(15));
            for (int k = 0; k < 4; k++) begin
                rdy[k] = ($urandom_range(3) != 0);
                rsp[k] = ($urandom_range(3) == 0);
                rd[k]  = $urandom;
            end
            #1;
            model_outputs(er, ep, ed);
            check($sformatf("rnd%0d hready", n), {31'd0, HREADY}, {31'd0, er});
            check($sformatf("rnd%0d hresp", n), {31'd0, HRESP}, {31'd0, ep});
            check($sformatf("rnd%0d hrdata", n), HRDATA, ed);
            model_clock(er);
            @(posedge HCLK); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
